// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_e;

  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = 6;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate, used both to take operand magnitudes
// and to restore the sign of results.
module mdu_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic         neg_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] val_o
);

  // negate when requested, pass through otherwise
  always_comb begin
    if (neg_i) begin
      val_o = (~val_i) + {{(W-1){1'b0}}, 1'b1};
    end else begin
      val_o = val_i;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO.
// Optional MDU_EARLY_OUT_EN: MUL leaves early once the remaining multiplier bits are zero.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] rs_val_i,
  input  logic [WIDTH-1:0] rt_val_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  mdu_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d, hi_q, hi_d, lo_q, lo_d;
  logic                 neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic                 is_div_q, is_div_d, busy_q, busy_d, done_q, done_d;

  logic                 signed_op_s, rs_neg_s, rt_neg_s, last_s, mul_exit_s;
  logic [WIDTH-1:0]     rs_mag_s, rt_mag_s, quo_s, rem_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH:0]       diff_s;

  assign signed_op_s = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign rs_neg_s    = signed_op_s & rs_val_i[WIDTH-1];
  assign rt_neg_s    = signed_op_s & rt_val_i[WIDTH-1];

  mdu_sign_fix #(.W(WIDTH))   u_rs_mag   (.neg_i(rs_neg_s), .val_i(rs_val_i), .val_o(rs_mag_s));
  mdu_sign_fix #(.W(WIDTH))   u_rt_mag   (.neg_i(rt_neg_s), .val_i(rt_val_i), .val_o(rt_mag_s));
  mdu_sign_fix #(.W(2*WIDTH)) u_prod_fix (.neg_i(neg_lo_q), .val_i(acc_q), .val_o(prod_s));
  mdu_sign_fix #(.W(WIDTH))   u_quo_fix  (.neg_i(neg_lo_q), .val_i(acc_q[WIDTH-1:0]), .val_o(quo_s));
  mdu_sign_fix #(.W(WIDTH))   u_rem_fix  (.neg_i(neg_hi_q), .val_i(acc_q[2*WIDTH-1:WIDTH]), .val_o(rem_s));

  // Restoring trial subtract: acc holds {remainder, quotient} shifting left.
  assign diff_s = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mcand_q[WIDTH-1:0]};
  assign last_s = (cnt_q == CNT_W'(ITER - 1));

`ifdef MDU_EARLY_OUT_EN
  // The step that finds no multiplier bits left adds zero, so it can exit safely.
  assign mul_exit_s = last_s || ((cnt_q != {CNT_W{1'b0}}) && (mplier_q == {WIDTH{1'b0}}));
`else
  assign mul_exit_s = last_s;
`endif

  // next-state, datapath step and result commit
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    is_div_d = is_div_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          case (op_i)
            OP_MULT, OP_MULTU: begin
              mcand_d  = {{WIDTH{1'b0}}, rs_mag_s};
              mplier_d = rt_mag_s;
              acc_d    = {(2*WIDTH){1'b0}};
              neg_lo_d = rs_neg_s ^ rt_neg_s;
              neg_hi_d = 1'b0;
              is_div_d = 1'b0;
              cnt_d    = {CNT_W{1'b0}};
              state_d  = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              mcand_d  = {{WIDTH{1'b0}}, rt_mag_s};
              is_div_d = 1'b1;
              cnt_d    = {CNT_W{1'b0}};
              state_d  = ST_DIV;
              // Zero divisor: raw dividend through an all-ones quotient ends as the remainder.
              if (rt_val_i == {WIDTH{1'b0}}) begin
                acc_d    = {{WIDTH{1'b0}}, rs_val_i};
                neg_lo_d = 1'b0;
                neg_hi_d = 1'b0;
              end else begin
                acc_d    = {{WIDTH{1'b0}}, rs_mag_s};
                neg_lo_d = rs_neg_s ^ rt_neg_s;
                neg_hi_d = rs_neg_s;
              end
            end
            OP_MTHI: hi_d = rs_val_i;
            OP_MTLO: lo_d = rs_val_i;
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
        mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (mul_exit_s) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_DIV: begin
        if (!diff_s[WIDTH]) begin
          acc_d = {diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (last_s) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_FIX: begin
        if (is_div_q) begin
          hi_d = rem_s;
          lo_d = quo_s;
        end else begin
          hi_d = prod_s[2*WIDTH-1:WIDTH];
          lo_d = prod_s[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      mcand_q  <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      is_div_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      is_div_q <= is_div_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit; expected values are hand-computed.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int lat;
  int seen;
  int exp_lat_a, exp_lat_b;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start_i(start), .op_i(op),
    .rs_val_i(rs), .rt_val_i(rt),
    .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Presents a request, lets it be accepted, then counts edges until done (bounded).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int l);
    start = 1'b1; op = o; rs = a; rt = b;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    l = 0;
    while (done !== 1'b1 && l < 100) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; rs = 32'd0; rt = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b0;

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, lat);
    check("mult_lat", 32'(lat), 32'd33);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFF1);
    @(posedge clk); #1;
    check("done_pulse", {31'd0, done}, 32'd0);
    check("mult_hi_hold", hi, 32'hFFFF_FFFF);

    run_op(OP_DIVU, 32'd100, 32'd7, lat);
    check("divu_lat", 32'(lat), 32'd33);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);

    run_op(OP_DIV, 32'h0000_1234, 32'd0, lat);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'h0000_1234);

    run_op(OP_DIV, 32'hFFFF_FFF0, 32'd0, lat);
    check("div0_neg_lo", lo, 32'hFFFF_FFFF);
    check("div0_neg_hi", hi, 32'hFFFF_FFF0);

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'd0);

    run_op(OP_MULT, 32'd7, 32'hFFFF_FFFE, lat);
    check("mult_m14_hi", hi, 32'hFFFF_FFFF);
    check("mult_m14_lo", lo, 32'hFFFF_FFF2);

    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, lat);
    check("mult_min_lat", 32'(lat), 32'd33);
    check("mult_min_hi", hi, 32'h4000_0000);
    check("mult_min_lo", lo, 32'd0);

    // unused op code is ignored
    start = 1'b1; op = 3'd6; rs = 32'h1111_1111; rt = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    check("badop_busy", {31'd0, busy}, 32'd1 - 32'd1);
    check("badop_hi", hi, 32'h4000_0000);

    // MULTU in flight: ignored MTHI at cycle 5, reset at cycle 10
    start = 1'b1; op = OP_MULTU; rs = 32'hFFFF_FFFF; rt = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 5) begin
        start = 1'b1; op = OP_MTHI; rs = 32'hDEAD_BEEF;
      end
      if (i == 10) reset = 1'b1;
      @(posedge clk); #1;
      if (i == 5) begin
        start = 1'b0;
        check("ign_busy", {31'd0, busy}, 32'd1);
        check("ign_hi", hi, 32'h4000_0000);
        check("ign_lo", lo, 32'd0);
      end
    end
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    check("abort_quiet", 32'(seen), 32'd0);

    // MTHI then MTLO
    start = 1'b1; op = OP_MTHI; rs = 32'hCAFE_F00D;
    @(posedge clk); #1;
    check("mthi_hi", hi, 32'hCAFE_F00D);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_done", {31'd0, done}, 32'd0);
    op = OP_MTLO; rs = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    check("mtlo_lo", lo, 32'd1);
    check("mtlo_hi", hi, 32'hCAFE_F00D);
    check("mtlo_busy", {31'd0, busy}, 32'd0);

    // back-to-back: second start issued in the done cycle
    run_op(OP_MULTU, 32'd6, 32'd7, lat);
    check("b2b1_lo", lo, 32'd42);
    check("b2b1_hi", hi, 32'd0);
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, lat);
    check("b2b2_lat", 32'(lat), 32'd33);
    check("b2b2_hi", hi, 32'hFFFF_FFFF);
    check("b2b2_lo", lo, 32'hFFFF_FFFE);

`ifdef MDU_EARLY_OUT_EN
    exp_lat_a = 4;
    exp_lat_b = 3;
`else
    exp_lat_a = 33;
    exp_lat_b = 33;
`endif
    run_op(OP_MULTU, 32'd9, 32'd3, lat);
    check("eo_lat", 32'(lat), 32'(exp_lat_a));
    check("eo_lo", lo, 32'd27);
    check("eo_hi", hi, 32'd0);
    run_op(OP_MULTU, 32'd5, 32'd0, lat);
    check("eo_zero_lat", 32'(lat), 32'(exp_lat_b));
    check("eo_zero_lo", lo, 32'd0);
    run_op(OP_MULT, 32'hFFFF_FFF6, 32'hFFFF_FFFD, lat);
    check("eo_sgn_lat", 32'(lat), 32'(exp_lat_a));
    check("eo_sgn_lo", lo, 32'd30);
    check("eo_sgn_hi", hi, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
